// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the program-counter generator.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pc_pkg;

    localparam int          PC_WIDTH     = 32;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam int          PC_INC       = 4;
    localparam int          PC_RAS_DEPTH = 4;

    // Source of the next PC, listed from highest to lowest priority
    typedef enum logic [1:0] {
        SEL_EXC,
        SEL_REDIR,
        SEL_RET,
        SEL_SEQ
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, same-cycle replace-top, and flush.
// Latency: updates on the posedge after the request; top is a combinational read.
// Backpressure: none; a push when full overwrites the oldest entry, a pop when empty is dropped.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = PC_RAS_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp;

    // A simultaneous push and pop on a non-empty stack rewrites the top in place
    logic replace;
    assign replace = push & pop & ~empty;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign top   = mem[sp];

    // Stack pointer and occupancy; sp wraps so a push when full lands on the oldest slot
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sp    <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (replace) begin
            count <= count;
        end else if (push) begin
            sp <= sp + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            sp    <= sp - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset is needed
    always_ff @(posedge clock) begin
        if (!flush && push) begin
            if (replace) begin
                mem[sp] <= push_data;
            end else begin
                mem[sp + PW'(1)] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: exception > redirect > return > sequential, optional RAS (PC_GEN_RAS_EN).
// Latency: pc_next is combinational; pc, RAS and flags update on the following posedge.
// Backpressure: pc_write=0 stalls (pc, RAS held) unless exc_valid forces the trap vector.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter int               INC       = PC_INC,
    parameter int               RAS_DEPTH = PC_RAS_DEPTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pc_write,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_vector,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);

    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] ras_top;
    logic             ret_hit;
    logic             advance;
    pc_sel_e          sel;

    // Sequential successor wraps modulo 2^WIDTH by construction
    assign pc_seq  = pc + WIDTH'(INC);
    assign advance = exc_valid | pc_write;

`ifdef PC_GEN_RAS_EN
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic          take;
    logic          ras_push;
    logic          ras_pop;
    logic [CW-1:0] unused_ras_count;

    // Call/ret only act on an unstalled, non-trapping cycle; a trap flushes the stack
    assign take     = pc_write & ~exc_valid;
    assign ras_push = take & redirect_valid & call;
    assign ras_pop  = take & ret;
    assign ret_hit  = ret & ~ras_empty;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .resetn    (resetn),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (exc_valid),
        .push_data (pc_seq),
        .top       (ras_top),
        .count     (unused_ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Sticky overflow/underflow; a same-cycle push+pop is a replace and sets neither
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            if (ras_push && !ras_pop && ras_full) begin
                ras_ovf <= 1'b1;
            end
            if (ras_pop && !ras_push && ras_empty) begin
                ras_unf <= 1'b1;
            end
        end
    end
`else
    logic unused_ras_inputs;

    // Without a stack, ret falls through to sequential and call is a plain redirect
    assign ras_top           = '0;
    assign ret_hit           = 1'b0;
    assign ras_empty         = 1'b1;
    assign ras_full          = 1'b0;
    assign ras_ovf           = 1'b0;
    assign ras_unf           = 1'b0;
    assign unused_ras_inputs = call ^ ret ^ (RAS_DEPTH < 2);
`endif

    // Priority select of the next-PC source; an empty-stack return falls to sequential
    always_comb begin
        sel = SEL_SEQ;
        if (exc_valid) begin
            sel = SEL_EXC;
        end else if (redirect_valid) begin
            sel = SEL_REDIR;
        end else if (ret_hit) begin
            sel = SEL_RET;
        end
    end

    // Next-PC mux; a stall without a trap holds the current value
    always_comb begin
        pc_next = pc;
        if (advance) begin
            unique case (sel)
                SEL_EXC:   pc_next = exc_vector;
                SEL_REDIR: pc_next = redirect_target;
                SEL_RET:   pc_next = ras_top;
                default:   pc_next = pc_seq;
            endcase
        end
    end

    // PC register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc <= RESET_VEC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver pushes model expectations, monitor compares after each posedge.
// Latency: expected registered state checked #1 after the posedge following each stimulus.
// Backpressure: exercised through random pc_write stalls and stalled traps.
module tb_pc_gen;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h0000_0100;
    localparam int          D  = 4;
`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        pc_write = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_vector = '0;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;

    always #5 clock = ~clock;

    pc_gen #(
        .WIDTH     (W),
        .RESET_VEC (RV),
        .INC       (4),
        .RAS_DEPTH (D)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .pc_write        (pc_write),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call            (call),
        .ret             (ret),
        .exc_valid       (exc_valid),
        .exc_vector      (exc_vector),
        .pc              (pc),
        .pc_next         (pc_next),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .ras_ovf         (ras_ovf),
        .ras_unf         (ras_unf)
    );

    typedef struct {
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: PC value plus a queue of return addresses (back = newest)
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RV;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic pw, input logic rv, input logic c, input logic r,
                              input logic ev, input logic [31:0] tgt, input logic [31:0] vec,
                              output logic [31:0] nxt);
        logic [31:0] seq;
        logic [31:0] t;
        seq = m_pc + 32'd4;
        if (ev) begin
            nxt = vec;
            m_ras.delete();
        end else if (!pw) begin
            nxt = m_pc;
        end else begin
            nxt = rv ? tgt : seq;
            if (RAS_ON) begin
                if (rv && c) begin
                    if (r && m_ras.size() > 0) begin
                        m_ras[m_ras.size()-1] = seq;
                    end else begin
                        m_ras.push_back(seq);
                        if (m_ras.size() > D) begin
                            t = m_ras.pop_front();
                            m_ovf = 1'b1;
                        end
                    end
                end else if (r) begin
                    if (m_ras.size() > 0) begin
                        t = m_ras.pop_back();
                        if (!rv) nxt = t;
                    end else begin
                        m_unf = 1'b1;
                    end
                end
            end
        end
        m_pc = nxt;
    endtask

    // One stimulus cycle: drive at negedge, check pc_next, queue the expected post-edge state
    task automatic cyc(input logic pw, input logic rv, input logic c, input logic r,
                       input logic ev, input logic [31:0] tgt, input logic [31:0] vec);
        logic [31:0] nxt;
        exp_t        e;
        @(negedge clock);
        pc_write        = pw;
        redirect_valid  = rv;
        call            = c;
        ret             = r;
        exc_valid       = ev;
        redirect_target = tgt;
        exc_vector      = vec;
        model_step(pw, rv, c, r, ev, tgt, vec, nxt);
        #1;
        chk("pc_next", pc_next, nxt);
        e.pc    = nxt;
        e.empty = RAS_ON ? (m_ras.size() == 0) : 1'b1;
        e.full  = RAS_ON ? (m_ras.size() == D) : 1'b0;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
    endtask

    task automatic seq_n(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, '0, '0);
    endtask

    // Reset asserted between posedges with inputs idled, released at a negedge
    task automatic do_reset();
        @(posedge clock);
        #3;
        pc_write = 1'b0; redirect_valid = 1'b0; call = 1'b0; ret = 1'b0; exc_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_pc", pc, RV);
        chk("rst_empty", {31'b0, ras_empty}, 32'd1);
        chk("rst_full", {31'b0, ras_full}, 32'd0);
        chk("rst_ovf", {31'b0, ras_ovf}, 32'd0);
        chk("rst_unf", {31'b0, ras_unf}, 32'd0);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // Monitor: compare registered outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_empty", {31'b0, ras_empty}, {31'b0, e.empty});
                chk("sb_full", {31'b0, ras_full}, {31'b0, e.full});
                chk("sb_ovf", {31'b0, ras_ovf}, {31'b0, e.ovf});
                chk("sb_unf", {31'b0, ras_unf}, {31'b0, e.unf});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #12;
        chk("init_pc", pc, RV);
        chk("init_empty", {31'b0, ras_empty}, 32'd1);
        chk("init_ovf", {31'b0, ras_ovf}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Sequential fetch from the reset vector
        seq_n(3);
        @(posedge clock); #2;
        chk("seq_10c", pc, 32'h10C);

        // Call then return two cycles later
        cyc(1, 1, 0, 0, 0, 32'h200, '0);
        cyc(1, 1, 1, 0, 0, 32'h800, '0);
        seq_n(1);
        cyc(1, 0, 0, 1, 0, '0, '0);
        @(posedge clock); #2;
        chk("ret_pc", pc, RAS_ON ? 32'h204 : 32'h808);

        // Overflow with five calls, then drain past empty
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0, 32'h1000 + 32'(i) * 32'h100, '0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0, '0, '0);

        // Stalled redirects are held; a stalled trap still lands and flushes
        cyc(1, 1, 1, 0, 0, 32'h3000, '0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 32'h4000, '0);
        cyc(0, 0, 0, 0, 1, '0, 32'h80);
        @(posedge clock); #2;
        chk("exc_pc", pc, 32'h80);

        // Wrap at the top of the address space
        cyc(1, 1, 0, 0, 0, 32'hFFFF_FFF8, '0);
        seq_n(2);
        @(posedge clock); #2;
        chk("wrap_pc", pc, 32'h0);

        // Same-cycle call+ret replaces the top; a later ret returns to it
        cyc(1, 1, 1, 0, 0, 32'h300, '0);
        cyc(1, 1, 1, 1, 0, 32'h900, '0);
        cyc(1, 0, 0, 1, 0, '0, '0);
        cyc(1, 1, 0, 1, 0, 32'h2000, '0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                    $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
            end
        end

        // Reset in the middle of a call sequence
        cyc(1, 1, 1, 0, 0, 32'h500, '0);
        cyc(1, 1, 1, 0, 0, 32'h600, '0);
        do_reset();
        cyc(1, 1, 1, 0, 0, 32'h700, '0);
        seq_n(1);
        @(posedge clock); #2;
        chk("post_rst_pc", pc, 32'h704);

        @(negedge clock);
        pc_write = 1'b0; redirect_valid = 1'b0; call = 1'b0; ret = 1'b0; exc_valid = 1'b0;
        @(posedge clock); #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
